rt_line_ctrl: RTL and testbench
===============================

// Module: rt_line_ctrl
// PURPOSE
//  Sequencer for one RT_32_8_4 racetrack line (data/mask/program/pNML tracks, NP ports, NB/NP bits per segment).
//  Accepts READ / WRITE / LIM / HOME commands via valid-ready, positions the line by issuing shift pulses,
//  then drives read-current, write-enable and Bz field pulses; returns the NP-bit port result.
//  Sits between the LiM memory controller and the line instance; all line stimuli originate here.
// PARAMETERS
//  NB        32  bits per track
//  NP        8   read/write ports per track; NSP=NB/NP must be a power of 2 (checked at elaboration)
//  SHIFT_CYC 2   cycles current_m is held high per one-position shift
//  READ_CYC  2   cycles read current is held high
//  WRITE_CYC 2   cycles write enables are held per write phase
//  BZ_CYC    3   cycles Bz_m is held high for a LIM evaluation
// PORTS
//  clk_i         in  1      clock
//  rst_i         in  1      synchronous reset, active-high
//  req_valid_i   in  1      command valid
//  req_ready_o   out 1      high only in IDLE
//  req_op_i      in  2      0 READ, 1 WRITE, 2 LIM, 3 HOME
//  req_trk_i     in  2      0 data, 1 mask, 2 program (READ/WRITE); 3 illegal
//  req_offs_i    in  log2(NSP) bit offset within each segment
//  req_wdata_i   in  NP     write data, one bit per port
//  req_nor_i     in  1      LIM: 1 = NOR, 0 = NAND (drives Bz_s)
//  resp_valid_o  out 1      one-cycle pulse per completed command; no backpressure
//  resp_data_o   out NP     port data (READ/LIM), 0 for WRITE/HOME; held until next resp
//  pos_o         out log2(NSP) current line position
//  rt_rstn_o     out 1      line reset, = !rst_i (combinational)
//  current_s_o / current_m_o out 1 shift direction (1 = forward, pos+1) / shift pulse; fanned to all 4 tracks
//  bz_s_o / bz_m_o         out 1 field direction / field pulse
//  rd_cur_d_o / rd_cur_m_o / rd_cur_p_o out 1 read currents (d shared by data and pNML tracks)
//  wr_bit_{d,m,p}_o out 1 ; wr_en_{d,m,p}_o out NP  write value / per-port enables
//  r_port_{data,lim,mask,prog}_i in NP  line read ports
// BEHAVIOUR
//  Reset: state IDLE, pos 0, every output 0 except req_ready_o=1, rt_rstn_o=0. Reset mid-command aborts it,
//   emits no resp, and clears pos (line is physically reset through rt_rstn_o).
//  FSM: IDLE -> SHIFT_ON -> SHIFT_GAP -> (loop until pos==target) -> op phase -> RESP -> IDLE.
//  Accept when req_valid_i & req_ready_o (cycle T). target=req_offs_i (HOME: 0). Command fields registered at T.
//  Shift: d=|target-pos| steps; each step = SHIFT_CYC cycles current_m=1 plus 1 gap cycle current_m=0;
//   current_s stable for the whole step incl. gap; pos updates at the end of the gap. d=0 skips shifting.
//  READ: READ_CYC cycles rd_cur_<trk>=1; r_port_<trk> sampled on the last one; resp at T+d*(SHIFT_CYC+1)+READ_CYC+1.
//  WRITE: WR_ONE phase WRITE_CYC cycles, wr_bit=1, wr_en=wdata; then WR_ZERO phase, wr_bit=0, wr_en=~wdata.
//   WR_ONE skipped if wdata==0, WR_ZERO skipped if wdata all ones. Only selected track's enables toggle.
//  LIM: BZ_CYC cycles bz_m=1 with bz_s=req_nor_i (bz_s held one extra cycle after bz_m falls),
//   then READ_CYC cycles rd_cur_d=1, sample r_port_lim_i.
//  HOME: shift to 0 only; resp with data 0.
//  Mutual exclusion: never current_m with any rd_cur, wr_en or bz_m in the same cycle.
//  Illegal req_trk_i=3 on READ/WRITE: no line activity, immediate resp with data 0 (T+1).
//  pos never exceeds NSP-1 (overhead cells cover NSP-1 shifts).
// STRUCTURE
//  Package rt_ctrl_pkg: op_e, trk_e, state_e enums; helper for NSP/log2(NSP).
//  Sub-module rt_pulse_timer: loadable down-counter with done flag, reused for all pulse widths.
// TESTING
//  Reset then READ data offs 0 (pos 0) -> rd_cur_d 2 cycles, resp at T+3 with r_port_data_i value.
//  WRITE data offs 3 wdata 8'hA5 from pos 0 -> 3 forward steps (9 cycles), en=A5 bit=1, en=5A bit=0, pos_o=3.
//  READ mask offs 1 from pos 3 -> 2 backward steps, current_s=0, resp at T+9.
//  LIM nor=1 offs 2 -> bz_m 3 cycles with bz_s=1, rd_cur_d 2 cycles, resp_data=r_port_lim_i.
//  WRITE wdata 8'h00 and 8'hFF -> only WR_ZERO / only WR_ONE phase respectively.
//  rst_i asserted mid-shift -> next cycle all outputs 0, pos_o=0, no resp; then HOME -> resp at T+1.

Source files
------------

// File: rtl/rt_ctrl_pkg.sv
// Shared types and geometry helpers for the racetrack line sequencer.
// Enumerations encode the host command set, the track selector and the sequencer states.
package rt_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_LIM   = 2'd2,
    OP_HOME  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    TRK_DATA = 2'd0,
    TRK_MASK = 2'd1,
    TRK_PROG = 2'd2,
    TRK_ILL  = 2'd3
  } trk_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_ON,
    S_SHIFT_GAP,
    S_READ,
    S_WR_ONE,
    S_WR_ZERO,
    S_BZ,
    S_RESP
  } state_e;

  // Pulse timer width: every pulse width parameter must fit in TMR_W bits.
  localparam int TMR_W = 4;

  function automatic int nsp(input int nb, input int np);
    return nb / np;
  endfunction

  function automatic int pos_w(input int nb, input int np);
    return (nb / np > 1) ? $clog2(nb / np) : 1;
  endfunction

endpackage

// File: rtl/rt_pulse_timer.sv
// Loadable down-counter shared by every pulse phase; done_o flags the last cycle of a phase.
module rt_pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/rt_line_ctrl.sv
// Sequencer for one racetrack line: positions it with shift pulses, then drives the
// read / write / Bz field phases of the accepted command and returns the port result.
module rt_line_ctrl
  import rt_ctrl_pkg::*;
#(
  parameter int NB        = 32,
  parameter int NP        = 8,
  parameter int SHIFT_CYC = 2,
  parameter int READ_CYC  = 2,
  parameter int WRITE_CYC = 2,
  parameter int BZ_CYC    = 3,
  localparam int PW       = pos_w(NB, NP)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [1:0]    req_op_i,
  input  logic [1:0]    req_trk_i,
  input  logic [PW-1:0] req_offs_i,
  input  logic [NP-1:0] req_wdata_i,
  input  logic          req_nor_i,
  output logic          resp_valid_o,
  output logic [NP-1:0] resp_data_o,
  output logic [PW-1:0] pos_o,
  output logic          rt_rstn_o,
  output logic          current_s_o,
  output logic          current_m_o,
  output logic          bz_s_o,
  output logic          bz_m_o,
  output logic          rd_cur_d_o,
  output logic          rd_cur_m_o,
  output logic          rd_cur_p_o,
  output logic          wr_bit_d_o,
  output logic          wr_bit_m_o,
  output logic          wr_bit_p_o,
  output logic [NP-1:0] wr_en_d_o,
  output logic [NP-1:0] wr_en_m_o,
  output logic [NP-1:0] wr_en_p_o,
  input  logic [NP-1:0] r_port_data_i,
  input  logic [NP-1:0] r_port_lim_i,
  input  logic [NP-1:0] r_port_mask_i,
  input  logic [NP-1:0] r_port_prog_i
);

  localparam int NSP = nsp(NB, NP);

  if (((NSP & (NSP - 1)) != 0) || (NSP * NP != NB)) begin : g_bad_geometry
    $error("rt_line_ctrl: NB/NP must be an exact power of two");
  end

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  trk_e            trk_q, trk_d;
  logic [PW-1:0]   pos_q, pos_d, target_q, target_d;
  logic [NP-1:0]   wdata_q, wdata_d, resp_data_q, resp_data_d, rd_sample, wr_en_pat;
  logic            nor_q, nor_d, dir_q, dir_d, bz_hold_q, bz_hold_d;
  logic            tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val;

  // First phase after positioning; a write skips the phase whose enables would all be zero.
  function automatic state_e op_entry(input op_e op, input logic [NP-1:0] wd);
    case (op)
      OP_READ:  return S_READ;
      OP_WRITE: return (|wd) ? S_WR_ONE : S_WR_ZERO;
      OP_LIM:   return S_BZ;
      default:  return S_RESP;
    endcase
  endfunction

  function automatic logic [TMR_W-1:0] cyc_for(input state_e s);
    case (s)
      S_SHIFT_ON:          return TMR_W'(SHIFT_CYC - 1);
      S_READ:              return TMR_W'(READ_CYC - 1);
      S_WR_ONE, S_WR_ZERO: return TMR_W'(WRITE_CYC - 1);
      S_BZ:                return TMR_W'(BZ_CYC - 1);
      default:             return '0;
    endcase
  endfunction

  always_comb begin
    case (op_q)
      OP_LIM:  rd_sample = r_port_lim_i;
      OP_READ: begin
        case (trk_q)
          TRK_DATA: rd_sample = r_port_data_i;
          TRK_MASK: rd_sample = r_port_mask_i;
          TRK_PROG: rd_sample = r_port_prog_i;
          default:  rd_sample = '0;
        endcase
      end
      default: rd_sample = '0;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    trk_d       = trk_q;
    target_d    = target_q;
    wdata_d     = wdata_q;
    nor_d       = nor_q;
    dir_d       = dir_q;
    pos_d       = pos_q;
    resp_data_d = resp_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d     = op_e'(req_op_i);
          trk_d    = trk_e'(req_trk_i);
          target_d = (op_d == OP_HOME) ? '0 : req_offs_i;
          wdata_d  = req_wdata_i;
          nor_d    = req_nor_i;
          dir_d    = (target_d > pos_q);
          if ((op_d == OP_READ || op_d == OP_WRITE) && trk_d == TRK_ILL) state_d = S_RESP;
          else if (target_d != pos_q)                                      state_d = S_SHIFT_ON;
          else                                                             state_d = op_entry(op_d, wdata_d);
        end
      end
      S_SHIFT_ON:  if (tmr_done) state_d = S_SHIFT_GAP;
      S_SHIFT_GAP: begin
        if (tmr_done) begin
          pos_d   = dir_q ? pos_q + PW'(1) : pos_q - PW'(1);
          state_d = (pos_d == target_q) ? op_entry(op_q, wdata_q) : S_SHIFT_ON;
        end
      end
      S_READ:    if (tmr_done) state_d = S_RESP;
      S_WR_ONE:  if (tmr_done) state_d = (&wdata_q) ? S_RESP : S_WR_ZERO;
      S_WR_ZERO: if (tmr_done) state_d = S_RESP;
      S_BZ:      if (tmr_done) state_d = S_READ;
      default:   state_d = S_IDLE;
    endcase
    if (state_d == S_RESP && state_q != S_RESP)
      resp_data_d = (state_q == S_READ) ? rd_sample : '0;
    tmr_load  = (state_d != state_q);
    tmr_val   = cyc_for(state_d);
    bz_hold_d = (state_q == S_BZ) && (state_d != S_BZ);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ;
      trk_q       <= TRK_DATA;
      target_q    <= '0;
      wdata_q     <= '0;
      nor_q       <= 1'b0;
      dir_q       <= 1'b0;
      pos_q       <= '0;
      resp_data_q <= '0;
      bz_hold_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      trk_q       <= trk_d;
      target_q    <= target_d;
      wdata_q     <= wdata_d;
      nor_q       <= nor_d;
      dir_q       <= dir_d;
      pos_q       <= pos_d;
      resp_data_q <= resp_data_d;
      bz_hold_q   <= bz_hold_d;
    end
  end

  rt_pulse_timer #(.W(TMR_W)) u_tmr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // All line stimuli decode from the current state, so phases can never overlap.
  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_data_o  = resp_data_q;
  assign pos_o        = pos_q;
  assign rt_rstn_o    = !rst_i;
  assign current_m_o  = (state_q == S_SHIFT_ON);
  assign current_s_o  = dir_q && (state_q == S_SHIFT_ON || state_q == S_SHIFT_GAP);
  assign bz_m_o       = (state_q == S_BZ);
  assign bz_s_o       = nor_q && (bz_m_o || bz_hold_q);
  assign rd_cur_d_o   = (state_q == S_READ) && (op_q == OP_LIM || trk_q == TRK_DATA);
  assign rd_cur_m_o   = (state_q == S_READ) && (op_q == OP_READ) && (trk_q == TRK_MASK);
  assign rd_cur_p_o   = (state_q == S_READ) && (op_q == OP_READ) && (trk_q == TRK_PROG);

  assign wr_en_pat  = (state_q == S_WR_ONE)  ? wdata_q :
                      (state_q == S_WR_ZERO) ? ~wdata_q : '0;
  assign wr_bit_d_o = (state_q == S_WR_ONE) && (trk_q == TRK_DATA);
  assign wr_bit_m_o = (state_q == S_WR_ONE) && (trk_q == TRK_MASK);
  assign wr_bit_p_o = (state_q == S_WR_ONE) && (trk_q == TRK_PROG);
  assign wr_en_d_o  = (trk_q == TRK_DATA) ? wr_en_pat : '0;
  assign wr_en_m_o  = (trk_q == TRK_MASK) ? wr_en_pat : '0;
  assign wr_en_p_o  = (trk_q == TRK_PROG) ? wr_en_pat : '0;

endmodule

// File: tb/tb_rt_line_ctrl.sv
// Bench for rt_line_ctrl: directed scenarios then random commands, each checked against
// a command-level model (position, latency formula, per-phase pulse counts, result data).
module tb_rt_line_ctrl;

  localparam int NP = 8;
  localparam int PW = 2;
  localparam int SHIFT_CYC = 2, READ_CYC = 2, WRITE_CYC = 2, BZ_CYC = 3;

  logic          clk_i = 1'b0, rst_i = 1'b1, req_valid_i = 1'b0, req_nor_i = 1'b0;
  logic [1:0]    req_op_i = '0, req_trk_i = '0;
  logic [PW-1:0] req_offs_i = '0;
  logic [NP-1:0] req_wdata_i = '0;
  logic [NP-1:0] r_port_data_i = '0, r_port_lim_i = '0, r_port_mask_i = '0, r_port_prog_i = '0;
  logic          req_ready_o, resp_valid_o, rt_rstn_o, current_s_o, current_m_o, bz_s_o, bz_m_o;
  logic          rd_cur_d_o, rd_cur_m_o, rd_cur_p_o, wr_bit_d_o, wr_bit_m_o, wr_bit_p_o;
  logic [NP-1:0] resp_data_o, wr_en_d_o, wr_en_m_o, wr_en_p_o;
  logic [PW-1:0] pos_o;

  int errors = 0, checks = 0;
  int m_pos = 0;

  always #5 clk_i = ~clk_i;

  rt_line_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_trk_i(req_trk_i), .req_offs_i(req_offs_i), .req_wdata_i(req_wdata_i),
    .req_nor_i(req_nor_i), .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .pos_o(pos_o),
    .rt_rstn_o(rt_rstn_o), .current_s_o(current_s_o), .current_m_o(current_m_o),
    .bz_s_o(bz_s_o), .bz_m_o(bz_m_o), .rd_cur_d_o(rd_cur_d_o), .rd_cur_m_o(rd_cur_m_o),
    .rd_cur_p_o(rd_cur_p_o), .wr_bit_d_o(wr_bit_d_o), .wr_bit_m_o(wr_bit_m_o), .wr_bit_p_o(wr_bit_p_o),
    .wr_en_d_o(wr_en_d_o), .wr_en_m_o(wr_en_m_o), .wr_en_p_o(wr_en_p_o),
    .r_port_data_i(r_port_data_i), .r_port_lim_i(r_port_lim_i),
    .r_port_mask_i(r_port_mask_i), .r_port_prog_i(r_port_prog_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] line_outs();
    return 64'({resp_valid_o, resp_data_o, pos_o, current_s_o, current_m_o, bz_s_o, bz_m_o,
                rd_cur_d_o, rd_cur_m_o, rd_cur_p_o, wr_bit_d_o, wr_bit_m_o, wr_bit_p_o,
                wr_en_d_o, wr_en_m_o, wr_en_p_o});
  endfunction

  // Issues one command (entered just after a negedge) and checks the whole transaction.
  task automatic run_cmd(input int op, input int trk, input int offs, input logic [NP-1:0] wd,
                         input logic nr);
    int lat = 0, cm_n = 0, dir_bad = 0, excl = 0, rdy_n = 0, other_n = 0;
    int rd_d_n = 0, rd_m_n = 0, rd_p_n = 0, bz_m_n = 0, bz_s_n = 0, one_n = 0, zero_n = 0;
    int target, d, exp_lat;
    bit illegal, exp_dir, is_wr;
    logic [NP-1:0] exp_data, en;
    logic bt;

    r_port_data_i = NP'($urandom); r_port_lim_i  = NP'($urandom);
    r_port_mask_i = NP'($urandom); r_port_prog_i = NP'($urandom);

    illegal = (op < 2) && (trk == 3);
    target  = illegal ? m_pos : ((op == 3) ? 0 : offs);
    d       = (target > m_pos) ? target - m_pos : m_pos - target;
    exp_dir = (target > m_pos);
    is_wr   = (op == 1) && !illegal;
    exp_lat = 1;
    if (!illegal) begin
      exp_lat = d * (SHIFT_CYC + 1) + 1;
      case (op)
        0: exp_lat += READ_CYC;
        1: exp_lat += ((wd != 0) ? WRITE_CYC : 0) + ((wd != 8'hFF) ? WRITE_CYC : 0);
        2: exp_lat += BZ_CYC + READ_CYC;
        default: ;
      endcase
    end
    exp_data = '0;
    if (op == 2) exp_data = r_port_lim_i;
    else if (op == 0 && trk == 0) exp_data = r_port_data_i;
    else if (op == 0 && trk == 1) exp_data = r_port_mask_i;
    else if (op == 0 && trk == 2) exp_data = r_port_prog_i;

    check("ready_before_cmd", 64'(req_ready_o), 64'(1));
    req_valid_i = 1'b1; req_op_i = 2'(op); req_trk_i = 2'(trk); req_offs_i = PW'(offs);
    req_wdata_i = wd;  req_nor_i = nr;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_op_i = 2'($urandom); req_trk_i = 2'($urandom); req_offs_i = PW'($urandom);
    req_wdata_i = NP'($urandom); req_nor_i = 1'($urandom);

    for (int n = 1; n <= 200 && lat == 0; n++) begin
      if (n > 1) @(negedge clk_i);
      if (current_m_o) cm_n++;
      if (current_m_o && current_s_o !== exp_dir) dir_bad++;
      if (current_m_o && (rd_cur_d_o || rd_cur_m_o || rd_cur_p_o || bz_m_o ||
                          (|{wr_en_d_o, wr_en_m_o, wr_en_p_o}))) excl++;
      if (rd_cur_d_o) rd_d_n++;
      if (rd_cur_m_o) rd_m_n++;
      if (rd_cur_p_o) rd_p_n++;
      if (bz_m_o) bz_m_n++;
      if (bz_s_o) bz_s_n++;
      if (req_ready_o) rdy_n++;
      for (int k = 0; k < 3; k++) begin
        en = (k == 0) ? wr_en_d_o : (k == 1) ? wr_en_m_o : wr_en_p_o;
        bt = (k == 0) ? wr_bit_d_o : (k == 1) ? wr_bit_m_o : wr_bit_p_o;
        if (is_wr && k == trk) begin
          if (bt && en === wd) one_n++;
          else if (!bt && en != 0 && en === ~wd) zero_n++;
        end else if (bt || en != 0) other_n++;
      end
      if (resp_valid_o) lat = n;
    end

    check("resp_latency", 64'(lat), 64'(exp_lat));
    check("resp_data", 64'(resp_data_o), 64'(exp_data));
    check("pos_after", 64'(pos_o), 64'(target));
    check("shift_pulse_cycles", 64'(cm_n), 64'(d * SHIFT_CYC));
    check("shift_dir_bad", 64'(dir_bad), 64'(0));
    check("mutual_excl", 64'(excl), 64'(0));
    check("ready_while_busy", 64'(rdy_n), 64'(0));
    check("rd_cur_d_cycles", 64'(rd_d_n),
          64'((!illegal && ((op == 0 && trk == 0) || op == 2)) ? READ_CYC : 0));
    check("rd_cur_m_cycles", 64'(rd_m_n), 64'((op == 0 && trk == 1) ? READ_CYC : 0));
    check("rd_cur_p_cycles", 64'(rd_p_n), 64'((op == 0 && trk == 2) ? READ_CYC : 0));
    check("bz_m_cycles", 64'(bz_m_n), 64'((op == 2) ? BZ_CYC : 0));
    check("bz_s_cycles", 64'(bz_s_n), 64'((op == 2 && nr) ? BZ_CYC + 1 : 0));
    check("wr_one_cycles", 64'(one_n), 64'((is_wr && wd != 0) ? WRITE_CYC : 0));
    check("wr_zero_cycles", 64'(zero_n), 64'((is_wr && wd != 8'hFF) ? WRITE_CYC : 0));
    check("wr_other_track", 64'(other_n), 64'(0));

    @(negedge clk_i);
    check("resp_single_pulse", 64'(resp_valid_o), 64'(0));
    check("ready_after_resp", 64'(req_ready_o), 64'(1));
    check("resp_data_held", 64'(resp_data_o), 64'(exp_data));
    m_pos = target;
  endtask

  initial begin
    int resp_seen;
    int op, trk;
    logic [NP-1:0] wd;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("reset_outputs_zero", line_outs(), 64'(0));
    check("reset_ready", 64'(req_ready_o), 64'(1));
    check("reset_rt_rstn", 64'(rt_rstn_o), 64'(0));
    rst_i = 1'b0;
    #1;
    check("rt_rstn_released", 64'(rt_rstn_o), 64'(1));
    @(negedge clk_i);

    // Directed scenarios
    run_cmd(0, 0, 0, 8'h00, 1'b0);   // READ data at pos 0
    run_cmd(1, 0, 3, 8'hA5, 1'b0);   // WRITE data, 3 forward steps
    run_cmd(0, 1, 1, 8'h00, 1'b0);   // READ mask, 2 backward steps
    run_cmd(2, 0, 2, 8'h00, 1'b1);   // LIM NOR
    run_cmd(2, 1, 2, 8'h00, 1'b0);   // LIM NAND, no shift
    run_cmd(1, 1, 3, 8'h00, 1'b0);   // WRITE all zeros: only WR_ZERO
    run_cmd(1, 2, 0, 8'hFF, 1'b0);   // WRITE all ones: only WR_ONE
    run_cmd(0, 3, 3, 8'h00, 1'b0);   // illegal track READ
    run_cmd(1, 3, 2, 8'h3C, 1'b0);   // illegal track WRITE
    run_cmd(0, 2, 3, 8'h00, 1'b0);   // READ prog, 3 steps
    run_cmd(3, 0, 2, 8'h00, 1'b0);   // HOME from pos 3

    // Reset in the middle of a 3-step shift
    req_valid_i = 1'b1; req_op_i = 2'd0; req_trk_i = 2'd0; req_offs_i = PW'(3);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midshift_rst_outputs", line_outs(), 64'(0));
    check("midshift_rst_ready", 64'(req_ready_o), 64'(1));
    check("midshift_rt_rstn", 64'(rt_rstn_o), 64'(0));
    rst_i = 1'b0;
    resp_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (resp_valid_o) resp_seen++;
    end
    check("midshift_no_resp", 64'(resp_seen), 64'(0));
    check("midshift_pos_cleared", 64'(pos_o), 64'(0));
    m_pos = 0;
    run_cmd(3, 0, 0, 8'h00, 1'b0);   // HOME at pos 0: resp at T+1

    // Random commands
    for (int i = 0; i < 30; i++) begin
      op  = int'($urandom_range(0, 3));
      trk = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0:       wd = 8'h00;
        1:       wd = 8'hFF;
        default: wd = NP'($urandom);
      endcase
      run_cmd(op, trk, int'($urandom_range(0, 3)), wd, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
